// File: rtl/dff_pipe_scan_if.sv
// Signal bundle for dff_pipe_scan: advance/valid/data inputs, scan controls,
// and the registered outputs of the last stage.
`timescale 1ns/10ps
interface dff_pipe_scan_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic             VI;
  logic [WIDTH-1:0] D;
  logic             SE;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             VO;
  logic             SO;

  modport master (
    output E, VI, D, SE, SI,
    input  Q, VO, SO
  );

  modport slave (
    input  E, VI, D, SE, SI,
    output Q, VO, SO
  );
endinterface

// File: rtl/dff_pipe_scan.sv
// WIDTH x DEPTH register pipeline with per-stage valid bits and a full scan
// chain through every data bit. The data stages are held as one flat vector
// with stage k in bits [k*WIDTH +: WIDTH], so the scan chain order
// (stage 0 bit 0 first, last stage MSB last) is simply that vector's bit order.
`timescale 1ns/10ps
module dff_pipe_scan #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                CK,
  input  logic                R,
  dff_pipe_scan_if.slave      bus
);

  localparam int                 N       = WIDTH * DEPTH;
  localparam logic [N-1:0]       RST_VEC = {DEPTH{RESET_VAL}};

  logic [N-1:0]     stg_q;
  logic [DEPTH-1:0] vld_q;
  logic [N-1:0]     scan_nxt;
  logic [N-1:0]     pipe_nxt;
  logic [DEPTH-1:0] vld_nxt;

  // Next-state vectors for one scan shift and one pipeline advance. Loops
  // keep them legal for WIDTH=1 and DEPTH=1 where slices would go negative.
  always_comb begin
    scan_nxt    = '0;
    pipe_nxt    = '0;
    vld_nxt     = '0;
    scan_nxt[0] = bus.SI;
    for (int i = 1; i < N; i++) begin
      scan_nxt[i] = stg_q[i-1];
    end
    pipe_nxt[WIDTH-1:0] = bus.D;
    for (int i = WIDTH; i < N; i++) begin
      pipe_nxt[i] = stg_q[i-WIDTH];
    end
    vld_nxt[0] = bus.VI;
    for (int k = 1; k < DEPTH; k++) begin
      vld_nxt[k] = vld_q[k-1];
    end
  end

  // State update with priority reset > scan > advance > hold; valid bits
  // are outside the scan chain and hold while shifting.
  always_ff @(posedge CK) begin
    if (R) begin
      stg_q <= RST_VEC;
      vld_q <= '0;
    end else if (bus.SE) begin
      stg_q <= scan_nxt;
    end else if (bus.E) begin
      stg_q <= pipe_nxt;
      vld_q <= vld_nxt;
    end
  end

  assign bus.Q  = stg_q[N-1 -: WIDTH];
  assign bus.VO = vld_q[DEPTH-1];
  assign bus.SO = stg_q[N-1];

endmodule
